// File: rtl/fp16_mul_post.sv
// fp16_mul_post: two-stage post-processing for an FP16 multiplier.
//   Stage 1 resolves the Booth/Wallace sum/carry vectors into a 22-bit product and registers
//   the product, the unbiased-then-rebiased exponent, the sign and a special-case code.
//   Stage 2 normalizes, rounds to nearest-even, applies overflow/flush-to-zero and special
//   overrides, then registers the packed binary16 result.
//   A valid/ready handshake runs across both stages, so there is one result per cycle with no
//   backpressure and at most two entries are in flight.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid, in_ready    upstream handshake (in_ready is combinational)
//   so, co                22-bit sum/carry vectors of the 1.10 x 1.10 mantissa product
//   sign_a/b, exp_a/b     operand signs and biased exponents (bias 15)
//   cls_a/b               operand class: 00 normal, 01 zero, 10 inf, 11 NaN
//   out_valid, out_ready  downstream handshake
//   result                IEEE binary16 product
//   flags                 {ovf, unf, inx}; exists only when FP16_MUL_FLAGS_EN is defined
//
// Build option: define FP16_MUL_FLAGS_EN to add the flags port and its logic.

module fp16_mul_post (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:0] so,
  input  logic [21:0] co,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [4:0]  exp_a,
  input  logic [4:0]  exp_b,
  input  logic [1:0]  cls_a,
  input  logic [1:0]  cls_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
`ifdef FP16_MUL_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} spec_e;

  // Pipeline control
  logic v1_q, v2_q;
  logic adv1, adv2;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1 next-state
  logic [21:0] p_d;
  logic [7:0]  e_d;
  logic        s_d;
  spec_e       spec_d;
  logic        any_nan, any_inf, any_zero;

  assign p_d      = so + co;
  // Range is -15..47, which fits an 8-bit two's complement value.
  assign e_d      = {3'b000, exp_a} + {3'b000, exp_b} - 8'd15;
  assign s_d      = sign_a ^ sign_b;
  assign any_nan  = (cls_a == 2'b11) || (cls_b == 2'b11);
  assign any_inf  = (cls_a == 2'b10) || (cls_b == 2'b10);
  assign any_zero = (cls_a == 2'b01) || (cls_b == 2'b01);

  always_comb begin
    spec_d = SpNone;
    if (any_nan || (any_inf && any_zero)) spec_d = SpNan;
    else if (any_inf)                     spec_d = SpInf;
    else if (any_zero)                    spec_d = SpZero;
  end

  // Stage 1 registers
  logic [21:0]       p1_q;
  logic signed [7:0] e1_q;
  logic              s1_q;
  spec_e             spec1_q;

  // Stage 2 combinational normalize / round / pack
  logic              [9:0]  mant;
  logic              [10:0] mant_r;
  logic                     g, st, inc;
  logic signed       [9:0]  e_n;
  logic                     ovf, flush;
  logic              [15:0] res_d;

  always_comb begin
    mant = p1_q[19:10];
    g    = p1_q[9];
    st   = |p1_q[8:0];
    e_n  = {{2{e1_q[7]}}, e1_q};
    if (p1_q[21]) begin
      mant = p1_q[20:11];
      g    = p1_q[10];
      st   = |p1_q[9:0];
      e_n  = e_n + 10'sd1;
    end
    inc    = g && (st || mant[0]);
    mant_r = {1'b0, mant} + {10'd0, inc};
    // A rounding carry leaves mant_r[9:0] all zero, i.e. mantissa 0 at the next exponent.
    if (mant_r[10]) e_n = e_n + 10'sd1;
    ovf   = (e_n >= 10'sd31);
    flush = !ovf && (e_n <= 10'sd0);

    if (ovf)        res_d = {s1_q, 5'h1f, 10'h000};
    else if (flush) res_d = {s1_q, 15'h0000};
    else            res_d = {s1_q, e_n[4:0], mant_r[9:0]};

    unique case (spec1_q)
      SpNan:   res_d = 16'h7e00;
      SpInf:   res_d = {s1_q, 15'h7c00};
      SpZero:  res_d = {s1_q, 15'h0000};
      default: ;
    endcase
  end

`ifdef FP16_MUL_FLAGS_EN
  logic [2:0] flags_d;
  logic [2:0] flags_q;
  logic       unf;

  always_comb begin
    unf     = flush && (|p1_q);
    flags_d = 3'b000;
    // Flags describe the arithmetic path only; special overrides are exact.
    if (spec1_q == SpNone) flags_d = {ovf, unf, g || st || ovf || unf};
  end

  assign flags = flags_q;
`endif

  logic [15:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      p1_q    <= 22'd0;
      e1_q    <= 8'sd0;
      s1_q    <= 1'b0;
      spec1_q <= SpNone;
      res_q   <= 16'h0000;
`ifdef FP16_MUL_FLAGS_EN
      flags_q <= 3'b000;
`endif
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          p1_q    <= p_d;
          e1_q    <= e_d;
          s1_q    <= s_d;
          spec1_q <= spec_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          res_q <= res_d;
`ifdef FP16_MUL_FLAGS_EN
          flags_q <= flags_d;
`endif
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign result    = res_q;

endmodule
